// File: rtl/ps2_digit_entry_ctrl_if.sv
// ps2_digit_entry_ctrl_if: scancode-in / number-out bundle for the digit entry controller
//   in_valid/in_code/in_ready   : producer offers PS/2 set-2 bytes, taken on valid && ready
//   out_valid/out_value/out_count/out_ready : entered BCD number offered to the consumer
//   err                         : one-cycle overflow pulse
interface ps2_digit_entry_ctrl_if #(parameter int MAX_DIGITS = 4);
   logic                    in_valid;
   logic [7:0]              in_code;
   logic                    in_ready;
   logic                    out_valid;
   logic [4*MAX_DIGITS-1:0] out_value;
   logic [3:0]              out_count;
   logic                    out_ready;
   logic                    err;
   modport master (output in_valid, in_code, out_ready, input in_ready, out_valid, out_value, out_count, err);
   modport slave  (input in_valid, in_code, out_ready, output in_ready, out_valid, out_value, out_count, err);
endinterface

// File: rtl/ps2_digit_entry_ctrl.sv
// ps2_digit_entry_ctrl: collects PS/2 keypad digits into a BCD number with backspace/escape/enter editing
//   clk    : rising-edge clock
//   areset : asynchronous active-high reset
//   bus    : slave side of ps2_digit_entry_ctrl_if (byte input, number output, err pulse)
module ps2_digit_entry_ctrl #(
   parameter int MAX_DIGITS = 4
) (
   input logic                   clk,
   input logic                   areset,
   ps2_digit_entry_ctrl_if.slave bus
);
   localparam int VW = 4 * MAX_DIGITS;
   typedef enum logic [2:0] {IDLE, BRK, EXT, EXT_BRK, DONE} state_t;
   state_t          state_q, state_d;
   logic [VW-1:0]   value_q, value_d;
   logic [3:0]      count_q, count_d;
   logic            err_q, err_d;
   logic            is_digit;
   logic [3:0]      digit;
   logic            acc;
   assign bus.in_ready  = state_q != DONE;
   assign bus.out_valid = state_q == DONE;
   assign bus.out_value = value_q;
   assign bus.out_count = count_q;
   assign bus.err       = err_q;
   assign acc           = bus.in_valid && bus.in_ready;
   always_comb begin
      is_digit = 1'b1;
      digit    = 4'd0;
      case (bus.in_code)
         8'h45: digit = 4'd0;
         8'h16: digit = 4'd1;
         8'h1E: digit = 4'd2;
         8'h26: digit = 4'd3;
         8'h25: digit = 4'd4;
         8'h2E: digit = 4'd5;
         8'h36: digit = 4'd6;
         8'h3D: digit = 4'd7;
         8'h3E: digit = 4'd8;
         8'h46: digit = 4'd9;
         default: is_digit = 1'b0;
      endcase
   end
   always_comb begin
      state_d = state_q;
      value_d = value_q;
      count_d = count_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE: if (acc) begin
            if (is_digit) begin
               if (count_q < 4'(MAX_DIGITS)) begin
                  value_d = (value_q << 4) | VW'(digit);
                  count_d = count_q + 4'd1;
               end else err_d = 1'b1;
            end else if (bus.in_code == 8'h66) begin
               if (count_q != 4'd0) begin
                  value_d = value_q >> 4;
                  count_d = count_q - 4'd1;
               end
            end else if (bus.in_code == 8'h76) begin
               value_d = '0;
               count_d = 4'd0;
            end else if (bus.in_code == 8'h5A) state_d = count_q != 4'd0 ? DONE : IDLE;
            else if (bus.in_code == 8'hF0) state_d = BRK;
            else if (bus.in_code == 8'hE0) state_d = EXT;
         end
         BRK, EXT_BRK: if (acc) state_d = IDLE;
         EXT: if (acc) begin
            // keypad enter shares the plain enter rule; any other extended key is dropped
            state_d = bus.in_code == 8'hF0 ? EXT_BRK :
                      (bus.in_code == 8'h5A && count_q != 4'd0) ? DONE : IDLE;
         end
         DONE: if (bus.out_ready) begin
            state_d = IDLE;
            value_d = '0;
            count_d = 4'd0;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_q <= IDLE;
         value_q <= '0;
         count_q <= 4'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         value_q <= value_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end
endmodule

// File: tb/tb_ps2_digit_entry_ctrl.sv
// tb_ps2_digit_entry_ctrl: directed vector table, reset corner cases and random traffic against a digit-queue model
module tb_ps2_digit_entry_ctrl;
   localparam int MD = 4;
   logic clk = 1'b0;
   logic areset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   ps2_digit_entry_ctrl_if #(.MAX_DIGITS(MD)) bus ();
   ps2_digit_entry_ctrl #(.MAX_DIGITS(MD)) dut (.clk(clk), .areset(areset), .bus(bus));
   always #5 clk = ~clk;
   typedef struct {
      logic        v;
      logic [7:0]  code;
      logic        ordy;
      logic [15:0] val;
      logic [3:0]  cnt;
      logic        ovld;
      logic        er;
   } vec_t;
   vec_t tbl[$];
   int   q[$];
   bit   m_done, m_brk, m_ext;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic step(input logic v, input logic [7:0] c, input logic r);
      @(negedge clk);
      bus.in_valid  = v;
      bus.in_code   = c;
      bus.out_ready = r;
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
   endtask
   task automatic chk_all(input string tag, input logic [15:0] val, input logic [3:0] cnt, input logic vld, input logic er);
      chk({tag, ".value"}, 32'(bus.out_value), 32'(val));
      chk({tag, ".count"}, 32'(bus.out_count), 32'(cnt));
      chk({tag, ".valid"}, 32'(bus.out_valid), 32'(vld));
      chk({tag, ".ready"}, 32'(bus.in_ready), 32'(!vld));
      chk({tag, ".err"}, 32'(bus.err), 32'(er));
   endtask
   task automatic do_reset();
      @(negedge clk);
      areset = 1'b1;
      #2;
      areset = 1'b0;
   endtask
   function automatic int digit_of(input logic [7:0] c);
      logic [7:0] codes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
      for (int i = 0; i < 10; i++) if (codes[i] == c) return i;
      return -1;
   endfunction
   function automatic logic [15:0] model_value();
      int v = 0;
      foreach (q[i]) v = v * 16 + q[i];
      return 16'(v);
   endfunction
   task automatic model(input logic v, input logic [7:0] c, input logic r, output bit er);
      int d = digit_of(c);
      er = 0;
      if (m_done) begin
         if (r) begin
            q.delete();
            m_done = 0;
         end
      end else if (v) begin
         if (m_brk) begin
            m_brk = 0;
            m_ext = 0;
         end else if (m_ext) begin
            m_ext = 0;
            if (c == 8'hF0) m_brk = 1;
            else if (c == 8'h5A && q.size() > 0) m_done = 1;
         end else if (d >= 0) begin
            if (q.size() < MD) q.push_back(d);
            else er = 1;
         end else if (c == 8'h66) begin
            if (q.size() > 0) void'(q.pop_back());
         end else if (c == 8'h76) q.delete();
         else if (c == 8'h5A) m_done = q.size() > 0;
         else if (c == 8'hF0) m_brk = 1;
         else if (c == 8'hE0) m_ext = 1;
      end
   endtask
   initial begin
      bus.in_valid  = 1'b0;
      bus.in_code   = 8'h00;
      bus.out_ready = 1'b0;
      #2;
      chk_all("reset", 16'h0, 4'd0, 1'b0, 1'b0);
      tbl = '{
         '{1, 8'h16, 0, 16'h0001, 1, 0, 0}, '{1, 8'hF0, 0, 16'h0001, 1, 0, 0},
         '{1, 8'h16, 0, 16'h0001, 1, 0, 0}, '{1, 8'h1E, 0, 16'h0012, 2, 0, 0},
         '{1, 8'hF0, 0, 16'h0012, 2, 0, 0}, '{1, 8'h1E, 0, 16'h0012, 2, 0, 0},
         '{1, 8'h76, 0, 16'h0000, 0, 0, 0},
         '{1, 8'h16, 0, 16'h0001, 1, 0, 0}, '{1, 8'h16, 0, 16'h0011, 2, 0, 0},
         '{1, 8'h16, 0, 16'h0111, 3, 0, 0}, '{1, 8'h16, 0, 16'h1111, 4, 0, 0},
         '{1, 8'h45, 0, 16'h1111, 4, 0, 1}, '{1, 8'h45, 0, 16'h1111, 4, 0, 1},
         '{0, 8'h00, 0, 16'h1111, 4, 0, 0}, '{1, 8'h76, 0, 16'h0000, 0, 0, 0},
         '{1, 8'h25, 0, 16'h0004, 1, 0, 0}, '{1, 8'h66, 0, 16'h0000, 0, 0, 0},
         '{1, 8'h66, 0, 16'h0000, 0, 0, 0}, '{1, 8'hE0, 0, 16'h0000, 0, 0, 0},
         '{1, 8'h5A, 0, 16'h0000, 0, 0, 0},
         '{1, 8'h36, 0, 16'h0006, 1, 0, 0}, '{1, 8'h3D, 0, 16'h0067, 2, 0, 0},
         '{1, 8'h76, 0, 16'h0000, 0, 0, 0}, '{1, 8'h46, 0, 16'h0009, 1, 0, 0},
         '{1, 8'hE0, 0, 16'h0009, 1, 0, 0}, '{1, 8'hF0, 0, 16'h0009, 1, 0, 0},
         '{1, 8'h5A, 0, 16'h0009, 1, 0, 0}, '{1, 8'h5A, 0, 16'h0009, 1, 1, 0},
         '{1, 8'h16, 0, 16'h0009, 1, 1, 0}, '{0, 8'h00, 1, 16'h0000, 0, 0, 0},
         '{1, 8'h16, 0, 16'h0001, 1, 0, 0}, '{1, 8'h1E, 0, 16'h0012, 2, 0, 0},
         '{1, 8'h26, 0, 16'h0123, 3, 0, 0}, '{1, 8'h5A, 0, 16'h0123, 3, 1, 0},
         '{0, 8'h00, 0, 16'h0123, 3, 1, 0}, '{1, 8'h45, 0, 16'h0123, 3, 1, 0},
         '{1, 8'h45, 1, 16'h0000, 0, 0, 0}, '{1, 8'hE0, 0, 16'h0000, 0, 0, 0},
         '{1, 8'h5A, 0, 16'h0000, 0, 0, 0}, '{1, 8'h26, 0, 16'h0003, 1, 0, 0},
         '{1, 8'hE0, 0, 16'h0003, 1, 0, 0}, '{1, 8'h5A, 0, 16'h0003, 1, 1, 0},
         '{0, 8'h00, 1, 16'h0000, 0, 0, 0}
      };
      @(negedge clk);
      areset = 1'b0;
      foreach (tbl[i]) begin
         step(tbl[i].v, tbl[i].code, tbl[i].ordy);
         chk_all($sformatf("vec%0d", i), tbl[i].val, tbl[i].cnt, tbl[i].ovld, tbl[i].er);
      end
      step(1, 8'h25, 0);
      step(1, 8'h1E, 0);
      step(1, 8'h5A, 0);
      chk_all("done42", 16'h0042, 4'd2, 1'b1, 1'b0);
      @(negedge clk);
      #2;
      areset = 1'b1;
      #1;
      chk_all("arst_done", 16'h0, 4'd0, 1'b0, 1'b0);
      #1;
      areset = 1'b0;
      step(1, 8'h16, 0);
      step(1, 8'hE0, 0);
      do_reset();
      step(1, 8'h1E, 0);
      chk_all("arst_ext", 16'h0002, 4'd1, 1'b0, 1'b0);
      step(1, 8'hF0, 0);
      do_reset();
      step(1, 8'h26, 0);
      chk_all("arst_brk", 16'h0003, 4'd1, 1'b0, 1'b0);
      do_reset();
      q.delete();
      m_done = 0;
      m_brk  = 0;
      m_ext  = 0;
      begin
         logic [7:0] pool[12] = '{8'h16, 8'h1E, 8'h45, 8'h46, 8'h25, 8'h3E, 8'h66, 8'h76, 8'h5A, 8'hF0, 8'hE0, 8'h13};
         for (int n = 0; n < 3000; n++) begin
            logic       v = $urandom_range(0, 3) != 0;
            logic [7:0] c = pool[$urandom_range(0, 11)];
            logic       r = $urandom_range(0, 3) == 0;
            bit         er;
            step(v, c, r);
            model(v, c, r, er);
            chk_all($sformatf("rnd%0d", n), model_value(), 4'(q.size()), m_done, er);
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ps2_digit_entry_ctrl.md
PS2_DIGIT_ENTRY_CTRL -- requirements
Module: ps2_digit_entry_ctrl

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 4, meaning the maximum number of BCD digits held (legal range 1-8).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port areset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  scancode byte offered.
REQ-005 SHALL have port in_code  input  8  PS/2 set-2 scancode byte.
REQ-006 SHALL have port in_ready  output  1  byte accepted when in_valid && in_ready at clk edge.
REQ-007 SHALL have port out_valid  output  1  entered number available.
REQ-008 SHALL have port out_value  output  4*MAX_DIGITS  BCD number, least significant digit in bits [3:0].
REQ-009 SHALL have port out_count  output  4  number of digits entered (0..MAX_DIGITS).
REQ-010 SHALL have port out_ready  input  1  consumer takes the number.
REQ-011 SHALL have port err  output  1  one-cycle overflow pulse.

Function
REQ-012 SHALL implement states IDLE, BRK, EXT, EXT_BRK, DONE; in_ready = 1 in every state except DONE.
REQ-013 SHALL decode digit make codes: 45=0, 16=1, 1E=2, 26=3, 25=4, 2E=5, 36=6, 3D=7, 3E=8, 46=9.
REQ-014 In IDLE, an accepted digit with out_count < MAX_DIGITS SHALL shift out_value left 4 bits, insert the digit at [3:0], and increment out_count, all visible the cycle after acceptance.
REQ-015 In IDLE, an accepted digit with out_count == MAX_DIGITS SHALL leave value/count unchanged and pulse err high for exactly the following cycle.
REQ-016 In IDLE, accepted 0x66 (backspace) SHALL shift out_value right 4 bits (zero fill) and decrement out_count; with out_count == 0 it SHALL have no effect.
REQ-017 In IDLE, accepted 0x76 (escape) SHALL clear out_value and out_count to 0.
REQ-018 In IDLE, accepted 0x5A (enter) with out_count > 0 SHALL move to DONE; with out_count == 0 it SHALL be ignored.
REQ-019 In IDLE, accepted 0xF0 SHALL move to BRK; accepted 0xE0 SHALL move to EXT; all other codes SHALL be ignored, remaining in IDLE.
REQ-020 In BRK, the next accepted byte SHALL be discarded with no data effect, returning to IDLE.
REQ-021 In EXT, accepted 0xF0 SHALL move to EXT_BRK; accepted 0x5A (keypad enter) SHALL behave as REQ-018; any other byte SHALL be discarded, returning to IDLE.
REQ-022 In EXT_BRK, the next accepted byte SHALL be discarded, returning to IDLE.
REQ-023 out_valid SHALL be 1 exactly while in DONE, with out_value/out_count held stable.
REQ-024 In DONE with out_ready = 1 at a clk edge, the block SHALL clear out_value and out_count and return to IDLE (out_valid low, in_ready high the next cycle).
REQ-025 in_valid with in_ready = 0 SHALL not consume or alter any state; the producer holds the byte.
REQ-026 err SHALL be 0 in all cycles other than REQ-015 pulses; back-to-back overflow digits SHALL produce back-to-back pulses.

Reset
REQ-027 While areset = 1, state SHALL be IDLE, out_value = 0, out_count = 0, out_valid = 0, err = 0, in_ready = 1, independent of clk.
REQ-028 areset asserted mid-sequence (BRK, EXT, EXT_BRK, DONE) SHALL abandon the sequence; first accepted byte after release is treated in IDLE.

Verification
REQ-029 Bytes 16,1E,26,5A with out_ready=0 -> out_valid=1, out_value=0x0123, out_count=3, in_ready=0 held; then out_ready=1 one cycle -> out_valid=0, value/count 0.
REQ-030 MAX_DIGITS=4: bytes 16,16,16,16,45 -> value 0x1111, count 4, err high one cycle after byte 45.
REQ-031 Bytes 16,F0,16,1E,F0,1E -> value 0x0012, count 2 (break-code bytes discarded).
REQ-032 Bytes 25,66,66,E0,5A -> first 66 gives count 0; second 66 no effect; E0 5A ignored (count 0), out_valid stays 0.
REQ-033 Bytes 36,3D,76,46,E0,F0,5A,5A -> value 0x0009 after 46; E0 F0 5A discarded; final 5A -> out_valid=1, value 0x0009, count 1.
REQ-034 areset pulse while in DONE with value 0x0042 -> out_valid=0, value 0, count 0, in_ready=1 immediately.
